// File: rtl/lei_multi.sv
// lei_multi: NCH requesters share one external solver port via round-robin, with a certificate ring cache.
// Optional: define LEI_CERT_JOIN_EN to add the cert_joined XOR accumulator and its cert_join_clr input.
module lei_multi #(
  parameter int NCH            = 4,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int CERT_DEPTH     = 256,
  parameter int CERT_WRAP      = 1,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int IW = $clog2(CERT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    logic_req,
  input  logic [NCH*AW-1:0] logic_addr,
  output logic [NCH-1:0]    logic_ack,
  output logic [NCH*DW-1:0] logic_data,
  output logic [NCH-1:0]    logic_err,
  output logic              z3_req,
  output logic [AW-1:0]     z3_formula_addr,
  output logic [CW-1:0]     z3_chan,
  input  logic              z3_ack,
  input  logic [DW-1:0]     z3_result,
  input  logic              z3_sat,
  input  logic [31:0]       z3_cert_hash,
  output logic              cert_write,
  output logic [IW-1:0]     cert_addr,
  output logic [31:0]       cert_data,
  output logic [IW:0]       cert_count,
  output logic              cert_overflow,
  output logic [31:0]       lei_status,
  output logic              lei_error
`ifdef LEI_CERT_JOIN_EN
  ,
  input  logic              cert_join_clr,
  output logic [31:0]       cert_joined
`endif
);

  localparam int TW = 20;
  localparam logic [IW:0] FULL = (IW+1)'(CERT_DEPTH);

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT, PROCESS, STORE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     rr_ptr_q, rr_ptr_d, chan_q, chan_d, pick, next_rr;
  logic [AW-1:0]     addr_q, addr_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              z3_req_q, z3_req_d, sat_q, sat_d;
  logic [DW-1:0]     result_q, result_d;
  logic [31:0]       hash_q, hash_d, cert_data_q, cert_data_d;
  logic [NCH-1:0]    ack_q, ack_d, err_q, err_d, eligible;
  logic [NCH*DW-1:0] data_q, data_d;
  logic              cert_write_q, cert_write_d, overflow_q, overflow_d;
  logic              lei_error_q, lei_error_d, found;
  logic [IW-1:0]     cert_addr_q, cert_addr_d, wr_ptr_q, wr_ptr_d;
  logic [IW:0]       count_q, count_d;
  int                idx;

  // A channel already holding its ack high must finish the handshake before it can be served again.
  always_comb begin
    eligible = logic_req & ~ack_q;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NCH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
    next_rr = (int'(chan_q) == NCH - 1) ? '0 : chan_q + CW'(1);
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    chan_d       = chan_q;
    addr_d       = addr_q;
    timer_d      = timer_q;
    z3_req_d     = z3_req_q;
    result_d     = result_q;
    sat_d        = sat_q;
    hash_d       = hash_q;
    ack_d        = ack_q & logic_req;
    data_d       = data_q;
    err_d        = err_q;
    cert_write_d = 1'b0;
    cert_addr_d  = cert_addr_q;
    cert_data_d  = cert_data_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    lei_error_d  = lei_error_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          chan_d  = pick;
          addr_d  = logic_addr[pick*AW +: AW];
          timer_d = TW'(TIMEOUT_CYCLES);
          state_d = REQUEST;
        end
      end
      REQUEST: begin
        z3_req_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        // A solver answer arriving on the last timer cycle still counts as a completion.
        if (z3_ack) begin
          z3_req_d = 1'b0;
          result_d = z3_result;
          sat_d    = z3_sat;
          hash_d   = z3_cert_hash;
          state_d  = PROCESS;
        end else if (timer_q == '0) begin
          z3_req_d                 = 1'b0;
          data_d[chan_q*DW +: DW]  = '0;
          err_d[chan_q]            = 1'b1;
          ack_d[chan_q]            = 1'b1;
          lei_error_d              = 1'b1;
          rr_ptr_d                 = next_rr;
          state_d                  = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      PROCESS: begin
        data_d[chan_q*DW +: DW] = result_q;
        err_d[chan_q]           = 1'b0;
        ack_d[chan_q]           = 1'b1;
        lei_error_d             = 1'b0;
        state_d                 = STORE;
      end
      STORE: begin
        if (count_q != FULL || CERT_WRAP != 0) begin
          cert_write_d = 1'b1;
          cert_addr_d  = wr_ptr_q;
          cert_data_d  = hash_q;
          wr_ptr_d     = wr_ptr_q + IW'(1);
        end
        if (count_q != FULL) count_d = count_q + (IW+1)'(1);
        else                 overflow_d = 1'b1;
        rr_ptr_d = next_rr;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      chan_q       <= '0;
      addr_q       <= '0;
      timer_q      <= '0;
      z3_req_q     <= 1'b0;
      result_q     <= '0;
      sat_q        <= 1'b0;
      hash_q       <= '0;
      ack_q        <= '0;
      data_q       <= '0;
      err_q        <= '0;
      cert_write_q <= 1'b0;
      cert_addr_q  <= '0;
      cert_data_q  <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      lei_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      chan_q       <= chan_d;
      addr_q       <= addr_d;
      timer_q      <= timer_d;
      z3_req_q     <= z3_req_d;
      result_q     <= result_d;
      sat_q        <= sat_d;
      hash_q       <= hash_d;
      ack_q        <= ack_d;
      data_q       <= data_d;
      err_q        <= err_d;
      cert_write_q <= cert_write_d;
      cert_addr_q  <= cert_addr_d;
      cert_data_q  <= cert_data_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      lei_error_q  <= lei_error_d;
    end
  end

`ifdef LEI_CERT_JOIN_EN
  logic [31:0] joined_q, joined_d;

  always_comb begin
    joined_d = joined_q;
    if (cert_join_clr)     joined_d = '0;
    else if (cert_write_q) joined_d = joined_q ^ cert_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) joined_q <= '0;
    else        joined_q <= joined_d;
  end

  assign cert_joined = joined_q;
`endif

  assign logic_ack       = ack_q;
  assign logic_data      = data_q;
  assign logic_err       = err_q;
  assign z3_req          = z3_req_q;
  assign z3_formula_addr = addr_q;
  assign z3_chan         = chan_q;
  assign cert_write      = cert_write_q;
  assign cert_addr       = cert_addr_q;
  assign cert_data       = cert_data_q;
  assign cert_count      = count_q;
  assign cert_overflow   = overflow_q;
  assign lei_error       = lei_error_q;
  assign lei_status      = {16'h0, 4'h0, sat_q, 3'(state_q), 8'(chan_q)};

endmodule
